// File: rtl/apb_slave_pkg.sv
// Shared types and helpers for the parametrised APB completer.
package apb_slave_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, READY} apb_state_e;

  localparam int unsigned DATA_W_DFLT = 8;
  localparam int unsigned STRB_W      = DATA_W_DFLT / 8;
  localparam int unsigned WCNT_W      = 4;

  // Word addresses at or beyond the implemented depth get an error response.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
    return addr >= depth;
  endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// DEPTH x DATA_W storage: async clear, one byte-enabled write port, one combinational read port.
module apb_slave_regfile
  import apb_slave_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [DATA_W-1:0]   rdata
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  widx;
  logic [IDX_W-1:0]  ridx;

  assign widx = IDX_W'(waddr);
  assign ridx = IDX_W'(raddr);

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (we && !addr_err(32'(waddr), DEPTH)) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (wbe[b]) mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Out-of-range reads return zero so the index never leaves the array.
  always_comb begin
    rdata = '0;
    if (!addr_err(32'(raddr), DEPTH)) rdata = mem[ridx];
  end

endmodule

// File: rtl/apb_slave_param.sv
// Parametrised APB3/APB4 completer with wait states and PSLVERR on out-of-range addresses.
// Define APB_SLAVE_PSTRB_EN to add the pstrb port and byte-masked writes.
module apb_slave_param
  import apb_slave_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
`ifdef APB_SLAVE_PSTRB_EN
  input  logic [DATA_W/8-1:0] pstrb,
`endif
  output logic                pready,
  output logic                pslverr,
  output logic [DATA_W-1:0]   prdata
);

  localparam int unsigned NB        = DATA_W / 8;
  localparam int unsigned WCNT_INIT = (WAIT_STATES == 0) ? 0 : WAIT_STATES - 1;

  apb_state_e        state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q;
  logic              err_q;
  logic [WCNT_W-1:0] wcnt;
  logic [NB-1:0]     be_q;

  logic              setup_c;
  logic              err_c;
  logic [NB-1:0]     be_c;
  logic              we_c;
  logic [ADDR_W-1:0] raddr_c;
  logic [DATA_W-1:0] rdata_c;

  assign setup_c = psel && !penable;
  assign raddr_c = setup_c ? paddr : addr_q;

  // A read carrying strobes is an APB4 protocol error; a write's strobes become byte enables.
  always_comb begin
    err_c = addr_err(32'(paddr), DEPTH);
    be_c  = '1;
`ifdef APB_SLAVE_PSTRB_EN
    be_c  = pstrb;
    if (!pwrite && (pstrb != '0)) err_c = 1'b1;
`endif
  end

  assign we_c = (state == READY) && psel && penable && pready && write_q && !err_q;

  apb_slave_regfile #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_regfile (
    .pclk   (pclk),
    .preset (preset),
    .we     (we_c),
    .waddr  (addr_q),
    .wdata  (wdata_q),
    .wbe    (be_q),
    .raddr  (raddr_c),
    .rdata  (rdata_c)
  );

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      be_q    <= '0;
      wcnt    <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end else if (setup_c) begin
      // Setup phase from any state restarts the transfer.
      addr_q  <= paddr;
      wdata_q <= pwdata;
      write_q <= pwrite;
      err_q   <= err_c;
      be_q    <= be_c;
      if (WAIT_STATES == 0) begin
        state   <= READY;
        pready  <= 1'b1;
        pslverr <= err_c;
        prdata  <= (!pwrite && !err_c) ? rdata_c : '0;
      end else begin
        state   <= WAIT;
        wcnt    <= WCNT_W'(WCNT_INIT);
        pready  <= 1'b0;
        pslverr <= 1'b0;
        prdata  <= '0;
      end
    end else if (state != IDLE && !psel) begin
      state   <= IDLE;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end else begin
      case (state)
        WAIT: begin
          if (wcnt == '0) begin
            state   <= READY;
            pready  <= 1'b1;
            pslverr <= err_q;
            prdata  <= (!write_q && !err_q) ? rdata_c : '0;
          end else begin
            wcnt <= wcnt - WCNT_W'(1);
          end
        end
        READY: begin
          state   <= IDLE;
          pready  <= 1'b0;
          pslverr <= 1'b0;
          prdata  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_param.sv
// Directed bench for apb_slave_param across four parameter sets.
module tb_apb_slave_param;

  localparam int NI = 4;

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel    [NI];
  logic        penable [NI];
  logic        pwrite  [NI];
  logic [2:0]  paddr   [NI];
  logic [31:0] pwdata  [NI];
  logic [3:0]  pstrb   [NI];
  logic        pready  [NI];
  logic        pslverr [NI];
  logic [31:0] prd     [NI];
  logic [7:0]  rd0, rd1, rd2;
  logic [31:0] rd3;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rd;
  logic        er;
  int          w;

  always #5 pclk = ~pclk;

  assign prd[0] = 32'(rd0);
  assign prd[1] = 32'(rd1);
  assign prd[2] = 32'(rd2);
  assign prd[3] = rd3;

  apb_slave_param #(.DATA_W(8), .ADDR_W(3), .DEPTH(8), .WAIT_STATES(0)) u0 (
    .pclk(pclk), .preset(preset), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
    .paddr(paddr[0]), .pwdata(pwdata[0][7:0]),
`ifdef APB_SLAVE_PSTRB_EN
    .pstrb(pstrb[0][0:0]),
`endif
    .pready(pready[0]), .pslverr(pslverr[0]), .prdata(rd0));

  apb_slave_param #(.DATA_W(8), .ADDR_W(3), .DEPTH(8), .WAIT_STATES(3)) u1 (
    .pclk(pclk), .preset(preset), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
    .paddr(paddr[1]), .pwdata(pwdata[1][7:0]),
`ifdef APB_SLAVE_PSTRB_EN
    .pstrb(pstrb[1][0:0]),
`endif
    .pready(pready[1]), .pslverr(pslverr[1]), .prdata(rd1));

  apb_slave_param #(.DATA_W(8), .ADDR_W(3), .DEPTH(6), .WAIT_STATES(2)) u2 (
    .pclk(pclk), .preset(preset), .psel(psel[2]), .penable(penable[2]), .pwrite(pwrite[2]),
    .paddr(paddr[2]), .pwdata(pwdata[2][7:0]),
`ifdef APB_SLAVE_PSTRB_EN
    .pstrb(pstrb[2][0:0]),
`endif
    .pready(pready[2]), .pslverr(pslverr[2]), .prdata(rd2));

  apb_slave_param #(.DATA_W(32), .ADDR_W(3), .DEPTH(8), .WAIT_STATES(0)) u3 (
    .pclk(pclk), .preset(preset), .psel(psel[3]), .penable(penable[3]), .pwrite(pwrite[3]),
    .paddr(paddr[3]), .pwdata(pwdata[3]),
`ifdef APB_SLAVE_PSTRB_EN
    .pstrb(pstrb[3]),
`endif
    .pready(pready[3]), .pslverr(pslverr[3]), .prdata(rd3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete transfer; returns data/error seen in the pready cycle and the wait count.
  task automatic xfer(input int k, input logic wr, input logic [2:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rdata, output logic err,
                      output int waits);
    @(negedge pclk);
    psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr; paddr[k] = a; pwdata[k] = d; pstrb[k] = s;
    @(negedge pclk);
    penable[k] = 1'b1;
    waits = 0;
    while (!pready[k] && waits < 40) begin
      @(negedge pclk);
      waits++;
    end
    rdata = prd[k];
    err   = pslverr[k];
    @(negedge pclk);
    psel[k] = 1'b0; penable[k] = 1'b0;
    chk("pready_one_cycle", 32'(pready[k]), 32'd0);
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0;
      paddr[k] = '0; pwdata[k] = '0; pstrb[k] = '0;
    end
    preset = 1'b1;
    repeat (3) @(negedge pclk);
    chk("rst_pready", 32'(pready[0]), 32'd0);
    chk("rst_pslverr", 32'(pslverr[0]), 32'd0);
    chk("rst_prdata", prd[0], 32'd0);
    chk("rst_pready_ws", 32'(pready[1]), 32'd0);
    preset = 1'b0;

    for (int a = 0; a < 8; a++) begin
      xfer(0, 1'b0, 3'(a), 32'd0, 4'd0, rd, er, w);
      chk("rst_read_data", rd, 32'd0);
      chk("rst_read_err", 32'(er), 32'd0);
    end

    // Zero-wait write then read
    xfer(0, 1'b1, 3'd3, 32'hA5, 4'hF, rd, er, w);
    chk("zw_wr_err", 32'(er), 32'd0);
    chk("zw_wr_waits", 32'(w), 32'd0);
    xfer(0, 1'b0, 3'd3, 32'd0, 4'd0, rd, er, w);
    chk("zw_rd_data", rd, 32'hA5);
    chk("zw_rd_err", 32'(er), 32'd0);
    chk("zw_rd_waits", 32'(w), 32'd0);
    xfer(0, 1'b1, 3'd0, 32'h3C, 4'hF, rd, er, w);
    xfer(0, 1'b1, 3'd7, 32'hC3, 4'hF, rd, er, w);
    xfer(0, 1'b0, 3'd0, 32'd0, 4'd0, rd, er, w);
    chk("zw_rd_addr0", rd, 32'h3C);
    xfer(0, 1'b0, 3'd7, 32'd0, 4'd0, rd, er, w);
    chk("zw_rd_addr7", rd, 32'hC3);
    xfer(0, 1'b0, 3'd3, 32'd0, 4'd0, rd, er, w);
    chk("zw_rd_addr3_kept", rd, 32'hA5);

    // Three wait states
    xfer(1, 1'b1, 3'd2, 32'h5A, 4'hF, rd, er, w);
    chk("ws3_wr_waits", 32'(w), 32'd3);
    xfer(1, 1'b0, 3'd2, 32'd0, 4'd0, rd, er, w);
    chk("ws3_rd_waits", 32'(w), 32'd3);
    chk("ws3_rd_data", rd, 32'h5A);
    chk("ws3_rd_err", 32'(er), 32'd0);

    // DEPTH=6: out-of-range accesses
    xfer(2, 1'b1, 3'd5, 32'h11, 4'hF, rd, er, w);
    chk("d6_wr5_err", 32'(er), 32'd0);
    chk("d6_wr5_waits", 32'(w), 32'd2);
    xfer(2, 1'b1, 3'd7, 32'h55, 4'hF, rd, er, w);
    chk("d6_wr7_err", 32'(er), 32'd1);
    xfer(2, 1'b0, 3'd7, 32'd0, 4'd0, rd, er, w);
    chk("d6_rd7_err", 32'(er), 32'd1);
    chk("d6_rd7_data", rd, 32'd0);
    xfer(2, 1'b0, 3'd6, 32'd0, 4'd0, rd, er, w);
    chk("d6_rd6_err", 32'(er), 32'd1);
    xfer(2, 1'b0, 3'd1, 32'd0, 4'd0, rd, er, w);
    chk("d6_no_alias", rd, 32'd0);
    chk("d6_rd1_err", 32'(er), 32'd0);
    xfer(2, 1'b0, 3'd5, 32'd0, 4'd0, rd, er, w);
    chk("d6_rd5_data", rd, 32'h11);

    // Abort a write by dropping psel mid-wait
    @(negedge pclk);
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 3'd5; pwdata[2] = 32'h99;
    @(negedge pclk);
    penable[2] = 1'b1;
    @(negedge pclk);
    chk("abort_wait_low", 32'(pready[2]), 32'd0);
    psel[2] = 1'b0; penable[2] = 1'b0;
    @(negedge pclk);
    chk("abort_pready", 32'(pready[2]), 32'd0);
    chk("abort_pslverr", 32'(pslverr[2]), 32'd0);
    xfer(2, 1'b0, 3'd5, 32'd0, 4'd0, rd, er, w);
    chk("abort_old_data", rd, 32'h11);
    chk("abort_rd_waits", 32'(w), 32'd2);

    // 32-bit full-word path
    xfer(3, 1'b1, 3'd4, 32'hDEADBEEF, 4'hF, rd, er, w);
    xfer(3, 1'b0, 3'd4, 32'd0, 4'd0, rd, er, w);
    chk("w32_rd_data", rd, 32'hDEADBEEF);

`ifdef APB_SLAVE_PSTRB_EN
    xfer(3, 1'b1, 3'd1, 32'hFFFFFFFF, 4'hF, rd, er, w);
    xfer(3, 1'b1, 3'd1, 32'h11223344, 4'b0101, rd, er, w);
    chk("strb_wr_err", 32'(er), 32'd0);
    xfer(3, 1'b0, 3'd1, 32'd0, 4'd0, rd, er, w);
    chk("strb_merge", rd, 32'hFF22FF44);
    xfer(3, 1'b1, 3'd1, 32'h00000000, 4'b0000, rd, er, w);
    chk("strb0_wr_err", 32'(er), 32'd0);
    xfer(3, 1'b0, 3'd1, 32'd0, 4'd0, rd, er, w);
    chk("strb0_unchanged", rd, 32'hFF22FF44);
    xfer(3, 1'b0, 3'd1, 32'd0, 4'b0001, rd, er, w);
    chk("strb_rd_err", 32'(er), 32'd1);
    chk("strb_rd_data", rd, 32'd0);
`endif

    // Reset in the middle of a waited write commits nothing and clears memory
    @(negedge pclk);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 3'd6; pwdata[1] = 32'hEE;
    @(negedge pclk);
    penable[1] = 1'b1;
    @(negedge pclk);
    preset = 1'b1;
    #1;
    chk("midrst_pready", 32'(pready[1]), 32'd0);
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(negedge pclk);
    preset = 1'b0;
    xfer(1, 1'b0, 3'd6, 32'd0, 4'd0, rd, er, w);
    chk("midrst_no_commit", rd, 32'd0);
    xfer(1, 1'b0, 3'd2, 32'd0, 4'd0, rd, er, w);
    chk("midrst_mem_cleared", rd, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
